// File: rtl/eluks_boot_dma_if.sv
// Wishbone classic bundle between the ELUKS boot DMA master and the shared interconnect.
interface eluks_boot_dma_if #(
  parameter int WB_DATA = 32
);
  logic [WB_DATA-1:0]   wb_adr_o;
  logic [WB_DATA-1:0]   wb_dat_o;
  logic [WB_DATA-1:0]   wb_dat_i;
  logic                 wb_cyc_o;
  logic                 wb_stb_o;
  logic                 wb_we_o;
  logic [WB_DATA/8-1:0] wb_sel_o;
  logic [2:0]           wb_cti_o;
  logic [1:0]           wb_bte_o;
  logic                 wb_ack_i;
  logic                 wb_err_i;
  logic                 wb_rty_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/eluks_boot_dma.sv
// Wishbone boot engine: bus reset hold, ELUKS setup, byte-wise image fetch packed into RAM words.
// Optional BOOT_VERIFY_EN: read back every stored word and fail on a mismatch.
module eluks_boot_dma #(
  parameter int          WB_DATA       = 32,
  parameter logic [31:0] ELUKS_WB_ADDR = 32'h9200_0000,
  parameter logic [31:0] RAM_WB_ADDR   = 32'h0000_0000,
  parameter int          BLOCK_BYTES   = 512,
  parameter int          RST_HOLD_CYC  = 16,
  parameter int          ACK_TIMEOUT   = 1024,
  parameter int          MAX_RETRY     = 3
) (
  input  logic                wb_clk,
  input  logic                rst_n,
  output logic                bus_rst,
  eluks_boot_dma_if.master    wb,
  input  logic                start,
  input  logic [63:0]         psw,
  input  logic [31:0]         start_block,
  input  logic                hmac_enable,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2:0]          err_code,
  output logic [63:0]         exec_timer
);
  localparam int               BYTES      = WB_DATA / 8;
  localparam logic [WB_DATA-1:0] ELUKS_BASE = WB_DATA'(ELUKS_WB_ADDR);
  localparam logic [WB_DATA-1:0] RAM_BASE   = WB_DATA'(RAM_WB_ADDR);
  localparam logic [3:0]       LAST_BYTE  = 4'(BYTES - 1);

  typedef enum logic [3:0] {
    ST_RST_HOLD, ST_IDLE, ST_CFG, ST_RQST, ST_FETCH, ST_STORE, ST_VERIFY, ST_DONE, ST_FAIL
  } state_t;

  state_t             state_reg;
  logic               acc_wait_reg, cyc_reg, we_reg, acc_we;
  logic [WB_DATA-1:0] adr_reg, dat_reg, word_reg, word_fill, acc_adr, acc_dat, ram_adr;
  logic [2:0]         cfg_idx_reg;
  logic [3:0]         byte_idx_reg;
  logic [7:0]         retry_reg;
  logic [31:0]        hold_cnt_reg, tmo_cnt_reg, idx_reg, words_reg, words_calc, idx_next;
  logic               term_err, term_rty, term_ack;

  assign term_err   = wb.wb_err_i;
  assign term_rty   = wb.wb_rty_i & ~wb.wb_err_i;
  assign term_ack   = wb.wb_ack_i & ~wb.wb_err_i & ~wb.wb_rty_i;
  assign words_calc = (32'(wb.wb_dat_i[WB_DATA-2:0]) * 32'(BLOCK_BYTES)) / 32'(BYTES);
  assign idx_next   = idx_reg + 32'd1;
  assign ram_adr    = RAM_BASE + WB_DATA'(idx_reg) * WB_DATA'(BYTES);

  // First delivered byte lands in the most significant lane.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign word_fill[gi*8 +: 8] = (byte_idx_reg == 4'(BYTES - 1 - gi)) ?
                                    wb.wb_dat_i[7:0] : word_reg[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    acc_adr = '0;
    acc_dat = WB_DATA'(1);
    acc_we  = 1'b1;
    case (state_reg)
      ST_CFG: begin
        case (cfg_idx_reg)
          3'd0:    begin acc_adr = ELUKS_BASE + WB_DATA'(0); acc_dat = WB_DATA'(psw[63:32]);  end
          3'd1:    begin acc_adr = ELUKS_BASE + WB_DATA'(1); acc_dat = WB_DATA'(psw[31:0]);   end
          3'd2:    begin acc_adr = ELUKS_BASE + WB_DATA'(2); acc_dat = WB_DATA'(start_block); end
          3'd3:    begin acc_adr = ELUKS_BASE + WB_DATA'(4); acc_dat = WB_DATA'(hmac_enable); end
          default: begin acc_adr = ELUKS_BASE + WB_DATA'(3); acc_dat = WB_DATA'(start_block); end
        endcase
      end
      ST_RQST:   acc_adr = ELUKS_BASE + WB_DATA'(6);
      ST_FETCH:  acc_adr = ELUKS_BASE + WB_DATA'(5);
      ST_STORE:  begin acc_adr = ram_adr; acc_dat = word_reg; end
      ST_VERIFY: begin acc_adr = ram_adr; acc_dat = word_reg; acc_we = 1'b0; end
      default:   ;
    endcase
  end

  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_RST_HOLD;
      bus_rst      <= 1'b1;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 3'd0;
      exec_timer   <= 64'd0;
      cyc_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      word_reg     <= '0;
      acc_wait_reg <= 1'b0;
      cfg_idx_reg  <= 3'd0;
      byte_idx_reg <= 4'd0;
      retry_reg    <= 8'd0;
      hold_cnt_reg <= 32'd0;
      tmo_cnt_reg  <= 32'd0;
      idx_reg      <= 32'd0;
      words_reg    <= 32'd0;
    end else begin
      case (state_reg)
        ST_RST_HOLD: begin
          if (hold_cnt_reg == 32'(RST_HOLD_CYC - 1)) begin
            bus_rst   <= 1'b0;
            cpu_rst   <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 32'd1;
          end
        end
        ST_IDLE: begin
          cpu_rst <= 1'b0;
          if (start) begin
            exec_timer   <= 64'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 3'd0;
            busy         <= 1'b1;
            cpu_rst      <= 1'b1;
            cfg_idx_reg  <= 3'd0;
            retry_reg    <= 8'd0;
            acc_wait_reg <= 1'b0;
            state_reg    <= ST_CFG;
          end
        end
        ST_DONE, ST_FAIL: begin
          if (!start) state_reg <= ST_IDLE;
        end
        default: begin
          exec_timer <= exec_timer + 64'd1;
          if (!acc_wait_reg) begin
            cyc_reg      <= 1'b1;
            adr_reg      <= acc_adr;
            dat_reg      <= acc_dat;
            we_reg       <= acc_we;
            tmo_cnt_reg  <= 32'd0;
            acc_wait_reg <= 1'b1;
          end else if (term_err) begin
            cyc_reg <= 1'b0; busy <= 1'b0; cpu_rst <= 1'b0;
            error <= 1'b1; err_code <= 3'd2; state_reg <= ST_FAIL;
          end else if (term_rty) begin
            cyc_reg      <= 1'b0;
            acc_wait_reg <= 1'b0;
            if (retry_reg == 8'(MAX_RETRY)) begin
              busy <= 1'b0; cpu_rst <= 1'b0;
              error <= 1'b1; err_code <= 3'd4; state_reg <= ST_FAIL;
            end else begin
              retry_reg <= retry_reg + 8'd1;
            end
          end else if (term_ack) begin
            cyc_reg      <= 1'b0;
            acc_wait_reg <= 1'b0;
            retry_reg    <= 8'd0;
            case (state_reg)
              ST_CFG: begin
                if (cfg_idx_reg == 3'd4) state_reg <= ST_RQST;
                else cfg_idx_reg <= cfg_idx_reg + 3'd1;
              end
              ST_RQST: begin
                words_reg    <= words_calc;
                idx_reg      <= 32'd0;
                byte_idx_reg <= 4'd0;
                if (wb.wb_dat_i[WB_DATA-1]) begin
                  busy <= 1'b0; cpu_rst <= 1'b0;
                  error <= 1'b1; err_code <= 3'd1; state_reg <= ST_FAIL;
                end else if (words_calc == 32'd0) begin
                  busy <= 1'b0; cpu_rst <= 1'b0; done <= 1'b1; state_reg <= ST_DONE;
                end else begin
                  state_reg <= ST_FETCH;
                end
              end
              ST_FETCH: begin
                word_reg <= word_fill;
                if (byte_idx_reg == LAST_BYTE) begin
                  byte_idx_reg <= 4'd0;
                  state_reg    <= ST_STORE;
                end else begin
                  byte_idx_reg <= byte_idx_reg + 4'd1;
                end
              end
`ifdef BOOT_VERIFY_EN
              ST_STORE: state_reg <= ST_VERIFY;
              ST_VERIFY: begin
                if (wb.wb_dat_i != word_reg) begin
                  busy <= 1'b0; cpu_rst <= 1'b0;
                  error <= 1'b1; err_code <= 3'd5; state_reg <= ST_FAIL;
                end else begin
                  idx_reg <= idx_next;
                  if (idx_next == words_reg) begin
                    busy <= 1'b0; cpu_rst <= 1'b0; done <= 1'b1; state_reg <= ST_DONE;
                  end else begin
                    state_reg <= ST_FETCH;
                  end
                end
              end
`else
              ST_STORE: begin
                idx_reg <= idx_next;
                if (idx_next == words_reg) begin
                  busy <= 1'b0; cpu_rst <= 1'b0; done <= 1'b1; state_reg <= ST_DONE;
                end else begin
                  state_reg <= ST_FETCH;
                end
              end
`endif
              default: ;
            endcase
          end else if (tmo_cnt_reg == 32'(ACK_TIMEOUT - 1)) begin
            cyc_reg <= 1'b0; busy <= 1'b0; cpu_rst <= 1'b0;
            error <= 1'b1; err_code <= 3'd3; state_reg <= ST_FAIL;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
      endcase
    end
  end

  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_dat_o = dat_reg;
  assign wb.wb_cyc_o = cyc_reg;
  assign wb.wb_stb_o = cyc_reg;
  assign wb.wb_we_o  = we_reg;
  assign wb.wb_sel_o = '1;
  assign wb.wb_cti_o = 3'b000;
  assign wb.wb_bte_o = 2'b00;
endmodule

// File: tb/tb_eluks_boot_dma.sv
// Bench for eluks_boot_dma: ELUKS/RAM slave model with scoreboards for config writes and RAM words.
module tb_eluks_boot_dma;
  localparam logic [31:0] ELUKS_BASE = 32'h9200_0000;
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] PSW0_EXP   = 32'h0123_4567;
  localparam logic [31:0] PSW1_EXP   = 32'h89AB_CDEF;
  localparam logic [31:0] SBLK       = 32'h0000_0007;

  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;

  logic        wb_clk = 1'b0;
  logic        rst_n, bus_rst, start, hmac_enable;
  logic [63:0] psw;
  logic [31:0] start_block;
  logic        cpu_rst, busy, done, error;
  logic [2:0]  err_code;
  logic [63:0] exec_timer;

  eluks_boot_dma_if #(.WB_DATA(32)) bus ();

  eluks_boot_dma dut (
    .wb_clk(wb_clk), .rst_n(rst_n), .bus_rst(bus_rst), .wb(bus),
    .start(start), .psw(psw), .start_block(start_block), .hmac_enable(hmac_enable),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .exec_timer(exec_timer)
  );

  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0, n_bad = 0;
  wr_t cfg_q[$];
  wr_t ram_q[$];
  logic [31:0] ram [logic [31:0]];
  logic [31:0] status_val = 32'd0, acc_word = 32'd0;
  logic [7:0]  byte_val = 8'd0;
  int nbyte = 0, pushed = 0, ram_writes = 0, cfg_cnt = 0, fetch_cnt = 0;
  int rty_budget = 0, err_cfg_n = 0, stall_at = 0, corrupt_word = -1;
  bit hang_all = 1'b0, prev_cyc = 1'b0;
  logic [1:0] resp = 2'd0;   // 0 none, 1 ack, 2 err, 3 rty

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic serve_access();
    logic [31:0] a, d, rd;
    wr_t e;
    a = bus.wb_adr_o;
    d = bus.wb_dat_o;
    resp = 2'd1;
    if (rty_budget > 0) begin
      rty_budget--;
      resp = 2'd3;
      return;
    end
    if (a[31:8] == ELUKS_BASE[31:8]) begin
      case (a[7:0])
        8'd5: begin
          fetch_cnt++;
          if (fetch_cnt == stall_at) resp = 2'd0;
          else begin
            bus.wb_dat_i = {24'h0, byte_val};
            acc_word = {acc_word[23:0], byte_val};
            byte_val++;
            nbyte++;
            if (nbyte == 4) begin
              nbyte = 0;
              e.adr = RAM_BASE + 32'(pushed * 4);
              e.dat = acc_word;
              ram_q.push_back(e);
              pushed++;
            end
          end
        end
        8'd6: begin
          check("rqs.dat", d, 64'd1);
          bus.wb_dat_i = status_val;
        end
        default: begin
          cfg_cnt++;
          if (cfg_q.size() > 0) begin
            e = cfg_q.pop_front();
            check("cfg.adr", a, e.adr);
            check("cfg.dat", d, e.dat);
          end
          if (cfg_cnt == err_cfg_n) resp = 2'd2;
        end
      endcase
    end else if (bus.wb_we_o) begin
      ram_writes++;
      ram[a] = d;
      if (ram_q.size() > 0) begin
        e = ram_q.pop_front();
        check("ram.adr", a, e.adr);
        check("ram.dat", d, e.dat);
      end
    end else begin
      rd = ram.exists(a) ? ram[a] : 32'd0;
      if (corrupt_word >= 0 && a == RAM_BASE + 32'(corrupt_word * 4)) rd = rd ^ 32'h0000_0100;
      bus.wb_dat_i = rd;
    end
    if (hang_all) resp = 2'd0;
  endtask

  initial begin
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0; bus.wb_dat_i = '0;
    forever begin
      @(negedge wb_clk);
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (!prev_cyc) serve_access();
      end else begin
        resp = 2'd0;
      end
      bus.wb_ack_i = (resp == 2'd1);
      bus.wb_err_i = (resp == 2'd2);
      bus.wb_rty_i = (resp == 2'd3);
      prev_cyc = bus.wb_cyc_o;
    end
  end

  task automatic prep_model(input logic [31:0] status);
    wr_t e;
    cfg_q.delete(); ram_q.delete(); ram.delete();
    byte_val = 8'd0; acc_word = 32'd0; nbyte = 0; pushed = 0;
    ram_writes = 0; cfg_cnt = 0; fetch_cnt = 0; status_val = status;
    e.adr = ELUKS_BASE + 32'd0; e.dat = PSW0_EXP;    cfg_q.push_back(e);
    e.adr = ELUKS_BASE + 32'd1; e.dat = PSW1_EXP;    cfg_q.push_back(e);
    e.adr = ELUKS_BASE + 32'd2; e.dat = SBLK;        cfg_q.push_back(e);
    e.adr = ELUKS_BASE + 32'd4; e.dat = 32'd1;       cfg_q.push_back(e);
    e.adr = ELUKS_BASE + 32'd3; e.dat = SBLK;        cfg_q.push_back(e);
  endtask

  task automatic run_boot(input string name, input logic [31:0] status, input bit exp_err,
                          input logic [2:0] exp_code, input int exp_writes, input int exp_cfg_left);
    int busy_cyc;
    bit fin;
    busy_cyc = 0;
    fin = 1'b0;
    prep_model(status);
    @(negedge wb_clk);
    start = 1'b1;
    for (int c = 0; c < 8000; c++) begin
      @(negedge wb_clk);
      if (busy) busy_cyc++;
      if (done || error) begin
        fin = 1'b1;
        break;
      end
    end
    check({name, ".finished"}, fin, 1);
    check({name, ".done"}, done, !exp_err);
    check({name, ".error"}, error, exp_err);
    check({name, ".err_code"}, err_code, exp_code);
    check({name, ".cpu_rst"}, cpu_rst, 0);
    check({name, ".cyc"}, bus.wb_cyc_o, 0);
    check({name, ".ram_writes"}, ram_writes, exp_writes);
    check({name, ".timer"}, exec_timer, busy_cyc);
    repeat (4) @(negedge wb_clk);
    check({name, ".timer_frozen"}, exec_timer, busy_cyc);
    check({name, ".busy"}, busy, 0);
    $display("run %-8s done=%0b error=%0b code=%0d timer=%0d ram_writes=%0d",
             name, done, error, err_code, exec_timer, ram_writes);
    start = 1'b0;
    repeat (3) @(negedge wb_clk);
    check({name, ".ram_q_left"}, ram_q.size(), 0);
    check({name, ".cfg_q_left"}, cfg_q.size(), exp_cfg_left);
  endtask

  task automatic hold_release(input string name);
    int n;
    n = 0;
    @(posedge wb_clk);
    #1 rst_n = 1'b1;
    check({name, ".bus_rst_hold"}, bus_rst, 1);
    check({name, ".cpu_rst_hold"}, cpu_rst, 1);
    do begin
      @(posedge wb_clk);
      #1 n++;
    end while (bus_rst && n < 100);
    check({name, ".hold_cycles"}, n, 16);
    check({name, ".cpu_rst_idle"}, cpu_rst, 0);
    check({name, ".cyc_idle"}, bus.wb_cyc_o, 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0;
    psw = 64'h0123_4567_89AB_CDEF; start_block = SBLK; hmac_enable = 1'b1;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst.bus_rst", bus_rst, 1);
    check("rst.cpu_rst", cpu_rst, 1);
    check("rst.cyc", bus.wb_cyc_o, 0);
    check("rst.status", {busy, done, error}, 3'b000);
    check("rst.err_code", err_code, 0);
    check("rst.timer", exec_timer, 0);
    hold_release("rst");

    run_boot("happy", 32'd1, 1'b0, 3'd0, 128, 0);
    check("happy.word0", ram[RAM_BASE], 32'h0001_0203);
    check("happy.last_addr", ram.exists(RAM_BASE + 32'h1FC), 1);

    run_boot("zero", 32'd0, 1'b0, 3'd0, 0, 0);
    run_boot("eluks", 32'h8000_0002, 1'b1, 3'd1, 0, 0);

    err_cfg_n = 3;
    run_boot("wb_err", 32'd1, 1'b1, 3'd2, 0, 2);
    err_cfg_n = 0;

    hang_all = 1'b1;
    run_boot("hang", 32'd1, 1'b1, 3'd3, 0, 4);
    check("hang.timer_1024", exec_timer, 64'd1025);
    hang_all = 1'b0;

    rty_budget = 4;
    run_boot("rty4", 32'd1, 1'b1, 3'd4, 0, 5);
    rty_budget = 3;
    run_boot("rty3", 32'd1, 1'b0, 3'd0, 128, 0);
    rty_budget = 0;

    corrupt_word = 5;
`ifdef BOOT_VERIFY_EN
    run_boot("verify", 32'd1, 1'b1, 3'd5, 6, 0);
`else
    run_boot("verify", 32'd1, 1'b0, 3'd0, 128, 0);
`endif
    corrupt_word = -1;

    stall_at = 10;
    found = 1'b0;
    prep_model(32'd1);
    @(negedge wb_clk);
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge wb_clk);
      if (fetch_cnt >= 10 && bus.wb_cyc_o) begin
        found = 1'b1;
        break;
      end
    end
    check("abort.reached_fetch10", found, 1);
    rst_n = 1'b0;
    #1;
    check("abort.cyc", bus.wb_cyc_o, 0);
    check("abort.bus_rst", bus_rst, 1);
    check("abort.cpu_rst", cpu_rst, 1);
    check("abort.busy", busy, 0);
    $display("run abort    fetch=%0d ram_writes=%0d", fetch_cnt, ram_writes);
    start = 1'b0;
    stall_at = 0;
    repeat (2) @(posedge wb_clk);
    hold_release("abort");
    run_boot("rerun", 32'd1, 1'b0, 3'd0, 128, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
